serial_frame_tx: RTL and testbench

//   Parallel-to-serial stage that feeds the serial shift-right register.
//   - Accepts a WIDTH-bit word over a valid/ready handshake.
//   - Emits the word LSB-first on serial_out, one bit per CLKS_PER_BIT clocks.
//   - After WIDTH shifts, a downstream right-shifting register that loads at its MSB holds the original word.
//   - Optional idle gap between frames; strobes mark bit sample points and frame end.

---
 rtl/serial_frame_tx.sv | 142 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: accepts a word on valid/ready and
// shifts it out LSB-first, CLKS_PER_BIT clocks per bit, with an optional idle gap.
module serial_frame_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_CYCLES   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int CMAX_RAW = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
  localparam int CMAX     = (CMAX_RAW > 1) ? CMAX_RAW : 1;
  localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW       = $clog2(WIDTH);

  localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_TC   = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [CW-1:0] GAP_TC   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic          ONE_CLK  = (CLKS_PER_BIT == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             data_ready_q, data_ready_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      data_ready_q <= 1'b1;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      data_ready_q <= data_ready_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // shift_en/frame_done are registered, so they are computed one clock ahead
  // from the counter value that will be current after this edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    data_ready_d = data_ready_q;
    shift_en_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_valid && data_ready_q) begin
          state_d      = SHIFT;
          shreg_d      = data_in;
          cnt_d        = '0;
          bit_d        = '0;
          data_ready_d = 1'b0;
          busy_d       = 1'b1;
          shift_en_d   = ONE_CLK;
        end
      end
      SHIFT: begin
        if (cnt_q == BIT_TC) begin
          cnt_d   = '0;
          // zero fill leaves the register clear once the last bit is gone
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
            end else begin
              state_d      = IDLE;
              busy_d       = 1'b0;
              data_ready_d = 1'b1;
            end
          end else begin
            bit_d        = bit_q + BW'(1);
            shift_en_d   = ONE_CLK;
            frame_done_d = ONE_CLK && (bit_q + BW'(1) == LAST_BIT);
          end
        end else begin
          cnt_d        = cnt_q + CW'(1);
          shift_en_d   = (cnt_q == PRE_TC);
          frame_done_d = (cnt_q == PRE_TC) && (bit_q == LAST_BIT);
        end
      end
      GAP: begin
        if (cnt_q == GAP_TC) begin
          cnt_d        = '0;
          state_d      = IDLE;
          busy_d       = 1'b0;
          data_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        cnt_d        = '0;
        bit_d        = '0;
        shreg_d      = '0;
        data_ready_d = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  assign serial_out = shreg_q[0];
  assign data_ready = data_ready_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances with different bit period / gap
// settings, checked cycle by cycle against a timing model of the frame.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       dv [3];
  logic [3:0] din[3];
  logic       dr [3];
  logic       so [3];
  logic       se [3];
  logic       bz [3];
  logic       fd [3];
  logic [3:0] q  [3];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
    .serial_out(so[0]), .shift_en(se[0]), .busy(bz[0]), .frame_done(fd[0]));
  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
    .serial_out(so[1]), .shift_en(se[1]), .busy(bz[1]), .frame_done(fd[1]));
  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
    .serial_out(so[2]), .shift_en(se[2]), .busy(bz[2]), .frame_done(fd[2]));

  // downstream right-shifting register loading at its MSB
  always @(posedge clk)
    for (int u = 0; u < 3; u++)
      if (se[u]) q[u] <= {so[u], q[u][3:1]};

  function automatic int cpb_of(int u);
    return (u == 1) ? 3 : 1;
  endfunction

  function automatic int gap_of(int u);
    return (u == 2) ? 2 : 0;
  endfunction

  // expected {serial_out, shift_en, frame_done, busy, data_ready} k clocks after accept
  function automatic logic [4:0] exp_vec(int k, int c, int g, logic [3:0] w);
    logic so_e, se_e, fd_e, bz_e;
    so_e = (k < 4*c) ? w[k/c] : 1'b0;
    se_e = (k < 4*c) && (k % c == c-1);
    fd_e = (k == 4*c-1);
    bz_e = (k < 4*c+g);
    return {so_e, se_e, fd_e, bz_e, ~bz_e};
  endfunction

  function automatic logic [4:0] got_vec(int u);
    return {so[u], se[u], fd[u], bz[u], dr[u]};
  endfunction

  // starts #1 after the accepting edge, ends #1 after the edge that makes the block ready again
  task automatic check_stream(int u, logic [3:0] w, string name);
    int c, g, n;
    logic [4:0] got, exp;
    c = cpb_of(u);
    g = gap_of(u);
    n = 4*c + g;
    for (int k = 0; k <= n; k++) begin
      got = got_vec(u);
      exp = exp_vec(k, c, g, w);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s u%0d k=%0d {so,se,fd,busy,rdy} got=%b exp=%b", name, u, k, got, exp);
      end
      if (k == 4*c) begin
        total++;
        if (q[u] !== w) begin
          bad++;
          $display("FAIL %s_q u%0d downstream got=%b exp=%b", name, u, q[u], w);
        end
      end
      if (k < n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_ready(int u, string name);
    int n = 0;
    @(negedge clk);
    while (!dr[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!dr[u]) begin
      bad++;
      $display("FAIL %s_timeout u%0d data_ready got=%b exp=1", name, u, dr[u]);
    end
  endtask

  task automatic test_frame(int u, logic [3:0] w, string name);
    wait_ready(u, name);
    dv[u]  = 1'b1;
    din[u] = w;
    @(posedge clk);
    #1;
    dv[u]  = 1'b0;
    din[u] = 4'($urandom);
    check_stream(u, w, name);
  endtask

  task automatic test_reset;
    logic [3:0] w, w2;
    #2 reset = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (got_vec(u) !== 5'b00001) begin
        bad++;
        $display("FAIL por_values u%0d got=%b exp=00001", u, got_vec(u));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    w  = 4'($urandom);
    w2 = 4'($urandom);
    wait_ready(1, "reset_mid");
    dv[1]  = 1'b1;
    din[1] = w;
    @(posedge clk);
    #1;
    dv[1] = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (got_vec(u) !== 5'b00001) begin
        bad++;
        $display("FAIL reset_async u%0d got=%b exp=00001", u, got_vec(u));
      end
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      total++;
      if (got_vec(1) !== 5'b00001) begin
        bad++;
        $display("FAIL reset_hold u1 got=%b exp=00001", got_vec(1));
      end
    end
    @(negedge clk);
    reset  = 1'b0;
    dv[1]  = 1'b1;
    din[1] = w2;
    @(posedge clk);
    #1;
    dv[1] = 1'b0;
    check_stream(1, w2, "post_reset");
  endtask

  task automatic test_back_to_back(int u, logic [3:0] w1, logic [3:0] w2, string name);
    wait_ready(u, name);
    dv[u]  = 1'b1;
    din[u] = w1;
    @(posedge clk);
    #1;
    din[u] = w2;
    check_stream(u, w1, name);
    @(posedge clk);
    #1;
    dv[u] = 1'b0;
    check_stream(u, w2, name);
  endtask

  task automatic test_ignore_busy(int u, string name);
    logic [3:0] w;
    int n;
    w = 4'($urandom);
    n = 4*cpb_of(u) + gap_of(u);
    wait_ready(u, name);
    dv[u]  = 1'b1;
    din[u] = w;
    @(posedge clk);
    #1;
    dv[u] = 1'b0;
    fork
      check_stream(u, w, name);
      begin
        for (int i = 1; i <= n; i++) begin
          @(negedge clk);
          dv[u]  = (i == 1) ? 1'b1 : 1'($urandom);
          din[u] = 4'($urandom);
        end
        @(negedge clk);
        dv[u] = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    total++;
    if (got_vec(u) !== 5'b00001) begin
      bad++;
      $display("FAIL %s_no_queue u%0d got=%b exp=00001", name, u, got_vec(u));
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 3; u++) begin
      dv[u]  = 1'b0;
      din[u] = 4'h0;
    end
    test_reset();
    test_frame(0, 4'b1011, "basic_1011");
    test_back_to_back(0, 4'b0110, 4'b1001, "b2b_nogap");
    test_frame(1, 4'b0001, "slow_0001");
    test_frame(2, 4'b1101, "gap_1101");
    test_back_to_back(2, 4'($urandom), 4'($urandom), "b2b_gap");
    test_ignore_busy(2, "ignore_gap");
    test_ignore_busy(1, "ignore_slow");
    for (int i = 0; i < 4; i++)
      for (int u = 0; u < 3; u++)
        test_frame(u, 4'($urandom), "random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
